// File: rtl/mdr_mem_unit.sv
// MAR/MDR stage driving single-word req/ack RAM transactions; done pulses the cycle after mem_ack; busy locks out bus loads.
// Build option MEM_TIMEOUT_EN: abort after TIMEOUT ack-less cycles and raise sticky err; otherwise wait on mem_ack forever.
module mdr_mem_unit #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] MDRdataOut,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              accept;
  logic              in_xact;
  logic              timeout_hit;

  // DONE accepts new commands exactly like IDLE so transactions can run back to back
  assign accept  = (state == IDLE) || (state == DONE);
  assign in_xact = (state == RD) || (state == WR);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // an ack in the final waiting cycle still completes normally
  assign timeout_hit = in_xact && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (!in_xact) begin
        wait_cnt <= '0;
      end else if (!mem_ack) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (MARin) begin
            mar <= BusMuxOut[ADDR_W-1:0];
          end
          if (MDRin && !Read) begin
            mdr <= BusMuxOut;
          end
          if (Read) begin
            state <= RD;
          end else if (Write) begin
            state <= WR;
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          if (mem_ack) begin
            mdr   <= mem_rdata;
            state <= DONE;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        WR: begin
          if (mem_ack) begin
            state <= DONE;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // every handshake output is a pure decode of registered state
  assign mem_req    = in_xact;
  assign mem_we     = (state == WR);
  assign busy       = in_xact;
  assign done       = (state == DONE);
  assign mem_addr   = mar;
  assign mem_wdata  = mdr;
  assign MDRdataOut = mdr;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Randomized bench for mdr_mem_unit: a variable-latency RAM responder plus a transaction-level MAR/MDR/memory model.
module tb_mdr_mem_unit;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          clear;
  logic [DW-1:0] BusMuxOut;
  logic          MARin, MDRin, Read, Write;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack, resp_ack, man_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req, mem_we, busy, done, err;
  logic [DW-1:0] MDRdataOut;

  assign mem_ack = resp_ack | man_ack;

  always #5 clock = ~clock;

  mdr_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .MDRdataOut(MDRdataOut), .busy(busy), .done(done), .err(err)
  );

  logic [DW-1:0] ram [512];
  logic [DW-1:0] mem_model [512];
  logic [AW-1:0] exp_mar;
  logic [DW-1:0] exp_mdr;
  bit            resp_en;
  int            lat_cfg;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // RAM responder: acks lat_cfg cycles after first seeing mem_req; junk on rdata otherwise
  initial begin : responder
    bit in_req;
    int wait_left;
    in_req = 0; wait_left = 0; resp_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      resp_ack  = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) begin
        in_req = 0;
      end else if (resp_en) begin
        if (!in_req) begin
          in_req    = 1;
          wait_left = lat_cfg;
        end
        if (wait_left == 0) begin
          resp_ack = 1'b1;
          if (mem_we) ram[mem_addr] = mem_wdata;
          else mem_rdata = ram[mem_addr];
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic idle_inputs();
    MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; BusMuxOut = '0;
  endtask

  task automatic model_reset();
    exp_mar = '0;
    exp_mdr = '0;
  endtask

  // one command cycle, then (for Read/Write) follow the transaction to completion
  task automatic xact(input logic [31:0] bus, input bit marin, input bit mdrin,
                      input bit rd, input bit wr, input int lat, input bit junk);
    int reqc;
    bit saw_done, addr_ok, data_ok, we_ok, is_rd;
    lat_cfg = lat;
    BusMuxOut = bus; MARin = marin; MDRin = mdrin; Read = rd; Write = wr;
    if (marin) exp_mar = bus[AW-1:0];
    if (mdrin && !rd) exp_mdr = bus;
    @(negedge clock);
    idle_inputs();
    if (!(rd || wr)) begin
      check_val("load_mar", 32'(mem_addr), 32'(exp_mar));
      check_val("load_mdr", MDRdataOut, exp_mdr);
      return;
    end
    is_rd = rd;
    reqc = 0; saw_done = 0; addr_ok = 1; data_ok = 1; we_ok = 1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        saw_done = 1;
        break;
      end
      if (mem_req) begin
        reqc++;
        if (mem_addr !== exp_mar) addr_ok = 0;
        if (mem_wdata !== exp_mdr) data_ok = 0;
        if (mem_we !== !is_rd) we_ok = 0;
        if (junk) begin
          BusMuxOut = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
          MARin = 1'($urandom_range(0, 1));
          MDRin = 1'($urandom_range(0, 1));
          Read  = 1'($urandom_range(0, 1));
          Write = 1'($urandom_range(0, 1));
        end
      end else begin
        idle_inputs();
      end
      @(negedge clock);
    end
    idle_inputs();
    check_val("done_seen", 32'(saw_done), 32'd1);
    check_val("req_cycles", reqc, lat + 1);
    check_val("addr_stable", 32'(addr_ok), 32'd1);
    check_val("wdata_stable", 32'(data_ok), 32'd1);
    check_val("we_level", 32'(we_ok), 32'd1);
    if (is_rd) exp_mdr = mem_model[exp_mar];
    else mem_model[exp_mar] = exp_mdr;
    check_val("mdr_at_done", MDRdataOut, exp_mdr);
    @(negedge clock);
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("busy_after", 32'(busy), 32'd0);
    check_val("mar_kept", 32'(mem_addr), 32'(exp_mar));
    if (!is_rd) check_val("ram_written", ram[exp_mar], exp_mdr);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt;
    bit saw;
    for (int i = 0; i < 512; i++) begin
      ram[i] = $urandom;
      mem_model[i] = ram[i];
    end
    resp_en = 1; lat_cfg = 0; man_ack = 1'b0;
    idle_inputs();
    clear = 1'b1;
    model_reset();
    @(negedge clock); @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // reset state, stray ack in IDLE
    check_val("rst_mdr", MDRdataOut, 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    man_ack = 1'b1;
    @(negedge clock);
    man_ack = 1'b0;
    @(negedge clock);
    check_val("idle_ack_busy", 32'(busy), 32'd0);
    check_val("idle_ack_done", 32'(done), 32'd0);
    check_val("idle_ack_mdr", MDRdataOut, 32'd0);

    // read with mem_req held 3 cycles
    ram[9'h075] = 32'hDEAD_BEEF;
    mem_model[9'h075] = 32'hDEAD_BEEF;
    xact(32'h0000_0075, 1, 0, 0, 0, 0, 0);
    xact(32'h0, 0, 0, 1, 0, 2, 0);
    check_val("read_deadbeef", MDRdataOut, 32'hDEAD_BEEF);

    // write with immediate ack, MDR loaded in the Write cycle
    xact(32'h0000_01FF, 1, 0, 0, 0, 0, 0);
    xact(32'h1234_5678, 0, 1, 0, 1, 0, 0);
    check_val("write_mdr_kept", MDRdataOut, 32'h1234_5678);

    // busy lockout with junk on every busy cycle; Read+Write picks read
    xact(32'h0000_0042, 1, 0, 1, 0, 4, 1);
    xact(32'h0000_0013, 1, 1, 1, 1, 1, 0);

    // back-to-back: Write completes, Read issued while done is high
    lat_cfg = 0;
    exp_mdr = 32'hA5A5_0F0F;
    BusMuxOut = exp_mdr; MDRin = 1'b1; Write = 1'b1;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    check_val("b2b_done", 32'(done), 32'd1);
    mem_model[exp_mar] = exp_mdr;
    exp_mar = 9'h033;
    BusMuxOut = 32'h0000_0033; MARin = 1'b1; Read = 1'b1;
    @(negedge clock);
    idle_inputs();
    check_val("b2b_req", 32'(mem_req), 32'd1);
    check_val("b2b_we", 32'(mem_we), 32'd0);
    check_val("b2b_addr", 32'(mem_addr), 32'h33);
    check_val("b2b_done_low", 32'(done), 32'd0);
    @(negedge clock);
    check_val("b2b_rd_done", 32'(done), 32'd1);
    exp_mdr = mem_model[exp_mar];
    check_val("b2b_rd_data", MDRdataOut, exp_mdr);
    @(negedge clock);

    // randomized command mix
    for (int t = 0; t < 40; t++) begin
      xact($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // clear in RD with ack pending, then a late ack
    xact(32'hCAFE_0001, 1, 1, 0, 0, 0, 0);
    resp_en = 0;
    Read = 1'b1;
    @(negedge clock);
    idle_inputs();
    check_val("midrd_req", 32'(mem_req), 32'd1);
    clear = 1'b1; man_ack = 1'b1;
    @(negedge clock);
    model_reset();
    check_val("midrd_req_drop", 32'(mem_req), 32'd0);
    check_val("midrd_mdr", MDRdataOut, 32'd0);
    check_val("midrd_busy", 32'(busy), 32'd0);
    clear = 1'b0; man_ack = 1'b0;
    @(negedge clock);
    man_ack = 1'b1;
    @(negedge clock);
    man_ack = 1'b0;
    @(negedge clock);
    check_val("late_ack_done", 32'(done), 32'd0);
    check_val("late_ack_mdr", MDRdataOut, 32'd0);
    check_val("late_ack_addr", 32'(mem_addr), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // write with no ack aborts after 15 requesting cycles
    exp_mdr = 32'h0BAD_F00D;
    BusMuxOut = exp_mdr; MDRin = 1'b1; Write = 1'b1;
    @(negedge clock);
    idle_inputs();
    cnt = 0; saw = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) cnt++;
      if (done) saw = 1;
      @(negedge clock);
    end
    check_val("to_req_cycles", cnt, 15);
    check_val("to_err", 32'(err), 32'd1);
    check_val("to_no_done", 32'(saw), 32'd0);
    check_val("to_mdr", MDRdataOut, exp_mdr);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_reset();
    check_val("to_err_clr", 32'(err), 32'd0);
`else
    cnt = 0; saw = 0;
    check_val("err_tied", 32'(err), 32'(saw));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
